// File: rtl/t05_pkg.sv
// Shared definitions for the Huffman tree builder: state encoding,
// default widths, node word field offsets and the NULL child code.
package t05_pkg;

  localparam int SYM_W_DEF     = 8;
  localparam int IDX_W_DEF     = 7;
  localparam int SUM_W_DEF     = 46;
  localparam int MAX_NODES_DEF = 128;
  localparam int CH_W_DEF      = SYM_W_DEF + 1;

  // Node word is {index, left, right, sum}, MSB first
  localparam int NODE_SUM_LSB   = 0;
  localparam int NODE_RIGHT_LSB = NODE_SUM_LSB + SUM_W_DEF;
  localparam int NODE_LEFT_LSB  = NODE_RIGHT_LSB + CH_W_DEF;
  localparam int NODE_IDX_LSB   = NODE_LEFT_LSB + CH_W_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_NODE = 3'd1,
    RD_L    = 3'd2,
    CLR_L   = 3'd3,
    RD_R    = 3'd4,
    CLR_R   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } htb_state_t;

  // NULL child code: 2'b11 in the top bits, zeros below
  function automatic logic [31:0] null_code(input int ch_w);
    null_code = 32'd3 << (ch_w - 2);
  endfunction

endpackage

// File: rtl/t05_htree_node_fmt.sv
// Node word formatting: packs a fresh node and builds the sum-cleared
// copy of a node read back from memory.
module t05_htree_node_fmt
  import t05_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int SUM_W = SUM_W_DEF,
  localparam int CH_W   = SYM_W + 1,
  localparam int NODE_W = IDX_W + 2*CH_W + SUM_W
) (
  input  logic [IDX_W-1:0]  pk_index,
  input  logic [CH_W-1:0]   pk_left,
  input  logic [CH_W-1:0]   pk_right,
  input  logic [SUM_W-1:0]  pk_sum,
  output logic [NODE_W-1:0] pk_word,
  input  logic [NODE_W-1:0] clr_src,
  output logic [NODE_W-1:0] clr_word
);

  assign pk_word  = {pk_index, pk_left, pk_right, pk_sum};
  assign clr_word = {clr_src[NODE_W-1:SUM_W], {SUM_W{1'b0}}};

endmodule

// File: rtl/t05_htree_builder.sv
// Huffman tree builder: writes one parent node per accepted pair, then
// zeroes the sum of each child node that is itself a sum node.
module t05_htree_builder
  import t05_pkg::*;
#(
  parameter int SYM_W     = SYM_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int MAX_NODES = MAX_NODES_DEF,
  localparam int CH_W   = SYM_W + 1,
  localparam int NODE_W = IDX_W + 2*CH_W + SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   least1,
  input  logic [CH_W-1:0]   least2,
  input  logic [SUM_W-1:0]  sum,
  output logic              mem_wr_req,
  output logic [IDX_W-1:0]  mem_wr_addr,
  output logic [NODE_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              mem_rd_req,
  output logic [IDX_W-1:0]  mem_rd_addr,
  input  logic [NODE_W-1:0] mem_rd_data,
  input  logic              mem_rd_ack,
  output logic [IDX_W:0]    node_count,
  output logic              done,
  output logic              tree_done,
  output logic              err
);

  localparam logic [CH_W-1:0] NULL_C = CH_W'(null_code(CH_W));
  localparam logic [IDX_W:0]  CAP_C  = (IDX_W+1)'(MAX_NODES);

  htb_state_t        state_r, state_s;
  logic [CH_W-1:0]   least1_r, least2_r;
  logic [SUM_W-1:0]  sum_r;
  logic [NODE_W-1:0] cap_r;
  logic [IDX_W:0]    node_count_r;
  logic              in_ready_r, done_r, tree_done_r, err_r;
  logic              wr_req_r, rd_req_r;
  logic [IDX_W-1:0]  wr_addr_r, rd_addr_r;
  logic [NODE_W-1:0] wr_data_r;

  logic              accept_s, wr_ack_s, rd_ack_s;
  logic              in_l1_null_s, in_l2_null_s, l1_null_s, l2_null_s;
  logic              l1_sum_s, l2_sum_s, single_s, tree_done_s;
  logic              wr_req_s, rd_req_s;
  logic [IDX_W-1:0]  wr_addr_s, rd_addr_s;
  logic [NODE_W-1:0] wr_data_s, pk_word_s, clr_word_s, clr_src_s;

  assign accept_s     = in_valid & in_ready_r & en;
  // Acks only count while the matching request is actually raised
  assign wr_ack_s     = mem_wr_ack & wr_req_r;
  assign rd_ack_s     = mem_rd_ack & rd_req_r;
  assign in_l1_null_s = (least1 == NULL_C);
  assign in_l2_null_s = (least2 == NULL_C);
  assign l1_null_s    = (least1_r == NULL_C);
  assign l2_null_s    = (least2_r == NULL_C);
  assign l1_sum_s     = least1_r[CH_W-1] & ~l1_null_s;
  assign l2_sum_s     = least2_r[CH_W-1] & ~l2_null_s;
  assign single_s     = (l1_null_s & ~least2_r[CH_W-1]) | (l2_null_s & ~least1_r[CH_W-1]);
  assign clr_src_s    = rd_ack_s ? mem_rd_data : cap_r;

  t05_htree_node_fmt #(.SYM_W(SYM_W), .IDX_W(IDX_W), .SUM_W(SUM_W)) u_fmt (
    .pk_index (node_count_r[IDX_W-1:0]),
    .pk_left  (accept_s ? least1 : least1_r),
    .pk_right (accept_s ? least2 : least2_r),
    .pk_sum   (accept_s ? sum : sum_r),
    .pk_word  (pk_word_s),
    .clr_src  (clr_src_s),
    .clr_word (clr_word_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !(in_l1_null_s && in_l2_null_s)) begin
          state_s = (node_count_r == CAP_C) ? ERR : WR_NODE;
        end else begin
          state_s = IDLE;
        end
      end
      WR_NODE: begin
        if (!en) state_s = IDLE;
        else if (wr_ack_s) state_s = l1_sum_s ? RD_L : (l2_sum_s ? RD_R : DONE);
        else state_s = WR_NODE;
      end
      RD_L: begin
        if (!en) state_s = IDLE;
        else if (rd_ack_s) state_s = CLR_L;
        else state_s = RD_L;
      end
      CLR_L: begin
        if (!en) state_s = IDLE;
        else if (wr_ack_s) state_s = l2_sum_s ? RD_R : DONE;
        else state_s = CLR_L;
      end
      RD_R: begin
        if (!en) state_s = IDLE;
        else if (rd_ack_s) state_s = CLR_R;
        else state_s = RD_R;
      end
      CLR_R: begin
        if (!en) state_s = IDLE;
        else if (wr_ack_s) state_s = DONE;
        else state_s = CLR_R;
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = ERR;
      default: state_s = IDLE;
    endcase
  end

  // Memory request values for the state being entered
  always_comb begin
    wr_req_s    = 1'b0;
    wr_addr_s   = {IDX_W{1'b0}};
    wr_data_s   = {NODE_W{1'b0}};
    rd_req_s    = 1'b0;
    rd_addr_s   = {IDX_W{1'b0}};
    tree_done_s = (accept_s && in_l1_null_s && in_l2_null_s) || ((state_s == DONE) && single_s);
    case (state_s)
      WR_NODE: begin
        wr_req_s  = 1'b1;
        wr_addr_s = node_count_r[IDX_W-1:0];
        wr_data_s = pk_word_s;
      end
      CLR_L: begin
        wr_req_s  = 1'b1;
        wr_addr_s = least1_r[IDX_W-1:0];
        wr_data_s = clr_word_s;
      end
      CLR_R: begin
        wr_req_s  = 1'b1;
        wr_addr_s = least2_r[IDX_W-1:0];
        wr_data_s = clr_word_s;
      end
      RD_L: begin
        rd_req_s  = 1'b1;
        rd_addr_s = least1_r[IDX_W-1:0];
      end
      RD_R: begin
        rd_req_s  = 1'b1;
        rd_addr_s = least2_r[IDX_W-1:0];
      end
      default: begin
        wr_req_s = 1'b0;
        rd_req_s = 1'b0;
      end
    endcase
  end

  // State, captured operands and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      least1_r     <= {CH_W{1'b0}};
      least2_r     <= {CH_W{1'b0}};
      sum_r        <= {SUM_W{1'b0}};
      cap_r        <= {NODE_W{1'b0}};
      node_count_r <= {(IDX_W+1){1'b0}};
      in_ready_r   <= 1'b0;
      done_r       <= 1'b0;
      tree_done_r  <= 1'b0;
      err_r        <= 1'b0;
      wr_req_r     <= 1'b0;
      wr_addr_r    <= {IDX_W{1'b0}};
      wr_data_r    <= {NODE_W{1'b0}};
      rd_req_r     <= 1'b0;
      rd_addr_r    <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        least1_r <= least1;
        least2_r <= least2;
        sum_r    <= sum;
      end
      if (rd_ack_s) cap_r <= mem_rd_data;
      if ((state_r == WR_NODE) && wr_ack_s) node_count_r <= node_count_r + (IDX_W+1)'(1);
      in_ready_r  <= (state_s == IDLE) && en;
      done_r      <= (state_s == DONE);
      tree_done_r <= tree_done_s;
      err_r       <= (state_s == ERR);
      wr_req_r    <= wr_req_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      rd_req_r    <= rd_req_s;
      rd_addr_r   <= rd_addr_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign mem_wr_req  = wr_req_r;
  assign mem_wr_addr = wr_addr_r;
  assign mem_wr_data = wr_data_r;
  assign mem_rd_req  = rd_req_r;
  assign mem_rd_addr = rd_addr_r;
  assign node_count  = node_count_r;
  assign done        = done_r;
  assign tree_done   = tree_done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_t05_htree_builder.sv
// Scoreboard bench for t05_htree_builder: directed pairs, a memory model
// that acks requests, and a monitor comparing every handshake and pulse.
module tb_t05_htree_builder;
  import t05_pkg::*;

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 done, 3 tree_done, 4 both
    logic [6:0]  addr;
    logic [70:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  least1 = 9'h000;
  logic [8:0]  least2 = 9'h000;
  logic [45:0] sum = 46'd0;
  logic        mem_wr_req, mem_rd_req;
  logic [6:0]  mem_wr_addr, mem_rd_addr;
  logic [70:0] mem_wr_data;
  logic [70:0] mem_rd_data = 71'd0;
  logic        mem_wr_ack = 1'b0;
  logic        mem_rd_ack = 1'b0;
  logic [7:0]  node_count;
  logic        done, tree_done, err;

  logic        wr_ack_en = 1'b1, rd_ack_en = 1'b1;
  logic        force_wr_ack = 1'b0, force_rd_ack = 1'b0;
  logic [70:0] mem [128];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  t05_htree_builder dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .least1(least1), .least2(least2), .sum(sum),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_rd_ack(mem_rd_ack),
    .node_count(node_count), .done(done), .tree_done(tree_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] mk(input int idx, input logic [8:0] l, input logic [8:0] r, input logic [45:0] s);
    logic [70:0] w;
    w = (71'(idx) << NODE_IDX_LSB) | (71'(l) << NODE_LEFT_LSB) | (71'(r) << NODE_RIGHT_LSB) | (71'(s) << NODE_SUM_LSB);
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input logic [6:0] a, input logic [70:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [6:0] a, input logic [70:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected kind=%0d addr=%0h data=%0h required=nothing", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL sb_event actual kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Memory model and monitor: sample away from the active edge
  always @(negedge clk) begin
    if (mem_wr_req || mem_rd_req) chk("req_exclusive", {126'd0, mem_wr_req, mem_rd_req} == 128'd3, 128'd0);
    if (done || tree_done) sb_pop((done && tree_done) ? 4 : (done ? 2 : 3), 7'd0, 71'd0);
    if (force_wr_ack) begin
      mem_wr_ack = 1'b1;
    end else if (mem_wr_req && wr_ack_en && !mem_wr_ack) begin
      mem_wr_ack = 1'b1;
      sb_pop(0, mem_wr_addr, mem_wr_data);
      mem[mem_wr_addr] = mem_wr_data;
    end else begin
      mem_wr_ack = 1'b0;
    end
    if (force_rd_ack) begin
      mem_rd_ack = 1'b1;
    end else if (mem_rd_req && rd_ack_en && !mem_rd_ack) begin
      mem_rd_ack  = 1'b1;
      mem_rd_data = mem[mem_rd_addr];
      sb_pop(1, mem_rd_addr, 71'd0);
    end else begin
      mem_rd_ack = 1'b0;
    end
  end

  task automatic send(input logic [8:0] l1, input logic [8:0] l2, input logic [45:0] s);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; least1 = l1; least2 = l2; sum = s;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) return;
    end
    chk("idle_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_node_count", 128'(node_count), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_reqs", 128'({mem_wr_req, mem_rd_req, done, tree_done}), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two leaves
    push(0, 7'd0, {7'd0, 9'h041, 9'h042, 46'd5});
    push(2, 7'd0, 71'd0);
    send(9'h041, 9'h042, 46'd5);
    wait_idle();
    chk("nc_after_leaf_pair", 128'(node_count), 128'd1);

    // Left child is sum node 0
    push(0, 7'd1, mk(1, 9'h100, 9'h043, 46'd9));
    push(1, 7'd0, 71'd0);
    push(0, 7'd0, {7'd0, 9'h041, 9'h042, 46'd0});
    push(2, 7'd0, 71'd0);
    send(9'h100, 9'h043, 46'd9);
    wait_idle();
    chk("nc_after_left_sum", 128'(node_count), 128'd2);

    // Single-character pair
    push(0, 7'd2, mk(2, 9'h041, 9'h180, 46'd7));
    push(4, 7'd0, 71'd0);
    send(9'h041, 9'h180, 46'd7);
    wait_idle();

    // Both children are sum nodes
    push(0, 7'd3, mk(3, 9'h101, 9'h100, 46'd20));
    push(1, 7'd1, 71'd0);
    push(0, 7'd1, mk(1, 9'h100, 9'h043, 46'd0));
    push(1, 7'd0, 71'd0);
    push(0, 7'd0, mk(0, 9'h041, 9'h042, 46'd0));
    push(2, 7'd0, 71'd0);
    send(9'h101, 9'h100, 46'd20);
    wait_idle();

    // Right child only is a sum node
    push(0, 7'd4, mk(4, 9'h050, 9'h102, 46'd30));
    push(1, 7'd2, 71'd0);
    push(0, 7'd2, mk(2, 9'h041, 9'h180, 46'd0));
    push(2, 7'd0, 71'd0);
    send(9'h050, 9'h102, 46'd30);
    wait_idle();
    chk("nc_after_right_sum", 128'(node_count), 128'd5);

    // NULL/NULL: tree_done the cycle after accept, no memory traffic
    push(3, 7'd0, 71'd0);
    send(9'h180, 9'h180, 46'd0);
    chk("null_pair_tree_done", 128'(tree_done), 128'd1);
    wait_idle();
    chk("nc_after_null_pair", 128'(node_count), 128'd5);

    // Abort during RD_L with the read ack withheld
    rd_ack_en = 1'b0;
    push(0, 7'd5, mk(5, 9'h103, 9'h041, 46'd11));
    send(9'h103, 9'h041, 46'd11);
    for (int n = 0; n < 40 && !mem_rd_req; n++) @(negedge clk);
    chk("abort_rd_req_seen", 128'(mem_rd_req), 128'd1);
    chk("abort_rd_addr", 128'(mem_rd_addr), 128'd3);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rd_req_drop", 128'(mem_rd_req), 128'd0);
    @(negedge clk);
    en = 1'b1;
    force_rd_ack = 1'b1;
    @(negedge clk);
    force_rd_ack = 1'b0;
    rd_ack_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_nc_kept", 128'(node_count), 128'd6);
    chk("abort_back_idle", 128'(in_ready), 128'd1);
    chk("abort_no_events", 128'(exp_q.size()), 128'd0);

    // Fill to capacity
    for (int i = 6; i < 128; i++) begin
      push(0, 7'(i), mk(i, 9'h041, 9'h042, 46'(i)));
      push(2, 7'd0, 71'd0);
      send(9'h041, 9'h042, 46'(i));
      wait_idle();
    end
    chk("nc_full", 128'(node_count), 128'd128);

    // Overflow: err, no write, in_ready held low
    send(9'h041, 9'h042, 46'd1);
    repeat (5) begin
      @(negedge clk);
      chk("ovf_err", 128'(err), 128'd1);
      chk("ovf_in_ready", 128'(in_ready), 128'd0);
      chk("ovf_nc", 128'(node_count), 128'd128);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_clears_err", 128'(err), 128'd0);
    chk("rst_clears_nc", 128'(node_count), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-write, then a late ack
    wr_ack_en = 1'b0;
    send(9'h041, 9'h042, 46'd1);
    @(negedge clk);
    chk("midrst_wr_req_seen", 128'(mem_wr_req), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_wr_req_drop", 128'(mem_wr_req), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    force_wr_ack = 1'b1;
    @(negedge clk);
    force_wr_ack = 1'b0;
    wr_ack_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_nc", 128'(node_count), 128'd0);
    chk("midrst_no_req", 128'(mem_wr_req), 128'd0);

    // Normal operation after recovery
    push(0, 7'd0, mk(0, 9'h041, 9'h042, 46'd3));
    push(2, 7'd0, 71'd0);
    send(9'h041, 9'h042, 46'd3);
    wait_idle();
    chk("recover_nc", 128'(node_count), 128'd1);
    chk("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t05_htree_builder.md
T05_HTREE_BUILDER -- requirements
Module: t05_htree_builder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 - SYM_W, 8: symbol width; child code width CH_W = SYM_W+1.
 - IDX_W, 7: node index width.
 - SUM_W, 46: frequency-sum width.
 - MAX_NODES, 128: node capacity; SHALL be <= 2**IDX_W.
 - NODE_W = IDX_W+2*CH_W+SUM_W (71 at defaults): derived node word width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
 - clk  in  1: the one clock; everything is rising-edge.
 - rst  in  1: synchronous, active-high reset.
 - en  in  1: operation enable from the controller; low means abort/idle.
 - in_valid  in  1: a least1/least2/sum triple is presented.
 - in_ready  out  1: builder can accept a triple.
 - least1, least2  in  CH_W: child codes. MSB=1 marks a sum node, index in [IDX_W-1:0]. NULL code = 2'b11 followed by zeros.
 - sum  in  SUM_W: parent frequency.
 - mem_wr_req  out  1; mem_wr_addr  out  IDX_W; mem_wr_data  out  NODE_W; mem_wr_ack  in  1.
 - mem_rd_req  out  1; mem_rd_addr  out  IDX_W; mem_rd_data  in  NODE_W; mem_rd_ack  in  1.
 - node_count  out  IDX_W+1: nodes written so far.
 - done  out  1: one-cycle pulse, pair fully processed.
 - tree_done  out  1: one-cycle pulse, tree complete.
 - err  out  1: sticky capacity overflow.

Function
REQ-003 Node word layout SHALL be {index[IDX_W], left[CH_W], right[CH_W], sum[SUM_W]}, MSB first.
REQ-004 The FSM SHALL have exactly these states: IDLE, WR_NODE, RD_L, CLR_L, RD_R, CLR_R, DONE, ERR.
REQ-005 in_ready SHALL be 1 only in IDLE with en=1 and err=0. A triple is accepted on in_valid & in_ready and registered that cycle.
REQ-006 Accept with least1=least2=NULL SHALL pulse tree_done the next cycle, with no memory access, and stay in IDLE.
REQ-007 Any other accept with node_count == MAX_NODES SHALL set err and go to ERR, with no write.
REQ-008 Any other accept SHALL go to WR_NODE.
 - WR_NODE holds mem_wr_req=1, addr=node_count[IDX_W-1:0], data={node_count, least1, least2, sum} until mem_wr_ack.
 - On ack, node_count increments.
REQ-009 After WR_NODE ack, the FSM SHALL go to RD_L if least1 is a non-NULL sum node, else RD_R if least2 is, else DONE.
REQ-010 RD_x SHALL hold mem_rd_req=1 with addr = the child index until mem_rd_ack, capture mem_rd_data on ack, then go to CLR_x.
REQ-011 CLR_x SHALL write back the captured word with its sum field zeroed (index and child fields unchanged), to the same address, holding the request until mem_wr_ack.
 - CLR_L then goes to RD_R if least2 is a non-NULL sum node, else DONE.
 - CLR_R goes to DONE.
REQ-012 DONE SHALL pulse done for one cycle, then return to IDLE.
 - Single-character pair (exactly one child NULL, other a leaf): tree_done SHALL pulse in the same cycle as done.
REQ-013 Only one memory request SHALL be outstanding at a time; mem_rd_req and mem_wr_req SHALL never both be 1.
REQ-014 An ack arriving while its request is low SHALL be ignored.
REQ-015 en=0 in any non-ERR state SHALL return the FSM to IDLE on the next edge.
 - All requests drop that edge; no done/tree_done is issued.
 - node_count keeps committed increments.
REQ-016 ERR SHALL be held until rst, with in_ready=0 and no memory requests.
REQ-017 All outputs SHALL be registered. Outputs not asserted by the current state SHALL be 0.

Reset
REQ-018 On rst=1 at a clock edge: state=IDLE, node_count=0, err=0, done=0, tree_done=0, all requests=0, addr/data outputs=0, captured registers=0.
REQ-019 Reset mid-transaction SHALL drop any request on the same edge. An ack arriving later SHALL be ignored.

Structure
REQ-020 The following SHALL live in shared package t05_pkg:
 - state enum htb_state_t;
 - NULL-code constant function;
 - node field-offset localparams.
REQ-021 The node-word pack/unpack and sum-clear logic SHALL be one sub-module, t05_htree_node_fmt (combinational, parametrised identically).

Verification (defaults)
REQ-022 least1=0x041, least2=0x042, sum=5 -> one write, addr 0, data {0,0x041,0x042,5}; done at the cycle after ack; node_count=1.
REQ-023 Then least1=0x100, least2=0x043, sum=9 -> write addr 1, read addr 0, rewrite addr 0 with sum field 0, done; node_count=2.
REQ-024 least1=0x041, least2=0x180 -> write {0,0x041,0x180,sum}; done and tree_done in the same cycle.
REQ-025 least1=least2=0x180 -> tree_done one cycle after accept; no mem_*_req ever high.
REQ-026 Preload node_count=128, send a valid pair -> err=1, no write, in_ready=0 until rst.
REQ-027 Drop en during RD_L with mem_rd_ack withheld -> mem_rd_req=0 next cycle; no done; a late ack is ignored.
